// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants, stage type and lane helpers for the VRAM byte port
package vram_pkg;

  localparam int VRAM_NB_COL     = 4;
  localparam int VRAM_COL_WIDTH  = 8;
  localparam int VRAM_WADDR_W    = 15;
  localparam int VRAM_RD_LATENCY = 2;
  localparam int VRAM_RSP_DEPTH  = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Helpers operate on the widest supported word; callers size-cast results down.
  localparam int VRAM_MAX_COLS   = 16;
  localparam int VRAM_MAX_COL_W  = 32;
  localparam int VRAM_MAX_BUS_W  = VRAM_MAX_COLS * VRAM_MAX_COL_W;
  localparam int VRAM_BUS_IDX_W  = clog2(VRAM_MAX_BUS_W);
  localparam int VRAM_COL_IDX_W  = clog2(VRAM_MAX_COL_W);

  typedef logic [VRAM_MAX_BUS_W-1:0] vram_bus_t;
  typedef logic [VRAM_MAX_COL_W-1:0] vram_col_t;
  typedef logic [VRAM_MAX_COLS-1:0]  vram_be_t;
  typedef logic [3:0]                vram_lane_t;

  typedef struct packed {
    logic       valid;
    vram_lane_t lane;
  } vram_rd_stage_t;

  function automatic vram_be_t lane_onehot(input vram_lane_t lane);
    vram_be_t r;
    r       = '0;
    r[lane] = 1'b1;
    return r;
  endfunction

  function automatic vram_bus_t lane_replicate(input vram_col_t col, input int col_w, input int nb);
    vram_bus_t r;
    for (int b = 0; b < VRAM_MAX_BUS_W; b++) begin
      r[b] = (b < col_w * nb) ? col[VRAM_COL_IDX_W'(b % col_w)] : 1'b0;
    end
    return r;
  endfunction

  function automatic vram_col_t lane_select(input vram_bus_t bus, input vram_lane_t lane, input int col_w);
    vram_col_t r;
    int        base;
    base = int'(lane) * col_w;
    for (int b = 0; b < VRAM_MAX_COL_W; b++) begin
      r[b] = (b < col_w) ? bus[VRAM_BUS_IDX_W'(base + b)] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/vram_rsp_fifo.sv
// rtl/vram_rsp_fifo.sv - first-word-fall-through response FIFO, pointers wrap modulo DEPTH
module vram_rsp_fifo
  import vram_pkg::*;
#(
  parameter int  COL_WIDTH = VRAM_COL_WIDTH,
  parameter int  DEPTH     = VRAM_RSP_DEPTH,
  localparam int PTR_W     = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CNT_W     = clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [COL_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [COL_WIDTH-1:0] pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count
);

  logic [COL_WIDTH-1:0] mem_q [DEPTH];
  logic [COL_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);

    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (!do_push && do_pop) count_d = count_q - CNT_W'(1);

    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;

    pop_data = empty ? '0 : mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vram_byte_port_ctrl.sv
// rtl/vram_byte_port_ctrl.sv - byte request sequencer driving a write-first byte-write VRAM port
module vram_byte_port_ctrl
  import vram_pkg::*;
#(
  parameter int NB_COL     = VRAM_NB_COL,
  parameter int COL_WIDTH  = VRAM_COL_WIDTH,
  parameter int WADDR_W    = VRAM_WADDR_W,
  parameter int RD_LATENCY = VRAM_RD_LATENCY,
  parameter int RSP_DEPTH  = VRAM_RSP_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [WADDR_W+clog2(NB_COL)-1:0]      req_addr,
  input  logic [COL_WIDTH-1:0]                  req_wdata,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [COL_WIDTH-1:0]                  rsp_rdata,
  output logic [WADDR_W-1:0]                    ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]           ram_din,
  output logic [NB_COL-1:0]                     ram_we,
  input  logic [NB_COL*COL_WIDTH-1:0]           ram_dout,
  output logic                                  busy
);

  localparam int LANE_W = clog2(NB_COL);
  localparam int DATA_W = NB_COL * COL_WIDTH;
  localparam int CNT_W  = clog2(RSP_DEPTH + 1);
  localparam int OUT_W  = clog2(RSP_DEPTH + RD_LATENCY + 1);

  logic [WADDR_W-1:0]   req_word;
  logic [LANE_W-1:0]    req_lane;
  logic                 accept;
  logic [OUT_W-1:0]     outstanding;
  logic                 any_inflight;
  vram_rd_stage_t       pipe_q [RD_LATENCY];
  vram_rd_stage_t       pipe_d [RD_LATENCY];
  logic [WADDR_W-1:0]   addr_q, addr_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [COL_WIDTH-1:0] fifo_push_data;
  logic [COL_WIDTH-1:0] fifo_pop_data;
  logic [CNT_W-1:0]     fifo_count;

  always_comb begin
    req_word = req_addr[WADDR_W+LANE_W-1:LANE_W];
    req_lane = req_addr[LANE_W-1:0];

    // Credits come only from registered state, so a pop frees its slot one cycle later.
    outstanding  = OUT_W'(fifo_count);
    any_inflight = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      outstanding  = outstanding + OUT_W'(pipe_q[i].valid);
      any_inflight = any_inflight | pipe_q[i].valid;
    end
    req_ready = !fifo_full && (outstanding < OUT_W'(RSP_DEPTH));
    accept    = req_valid && req_ready;

    pipe_d[0].valid = accept && !req_write;
    pipe_d[0].lane  = vram_lane_t'(req_lane);
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    addr_d = accept ? req_word : addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      addr_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      addr_q <= addr_d;
    end
  end

  assign ram_addr = addr_d;
  assign ram_din  = DATA_W'(lane_replicate(vram_col_t'(req_wdata), COL_WIDTH, NB_COL));
  assign ram_we   = (accept && req_write && rst_n) ? NB_COL'(lane_onehot(vram_lane_t'(req_lane))) : '0;

  // The last stage lines up with the RAM's registered read data.
  assign fifo_push      = pipe_q[RD_LATENCY-1].valid;
  assign fifo_push_data = COL_WIDTH'(lane_select(vram_bus_t'(ram_dout), pipe_q[RD_LATENCY-1].lane, COL_WIDTH));
  assign fifo_pop       = rsp_valid && rsp_ready;

  vram_rsp_fifo #(
    .COL_WIDTH (COL_WIDTH),
    .DEPTH     (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = fifo_pop_data;
  assign busy      = any_inflight || !fifo_empty;

endmodule
